st_ctrl: RTL and testbench
==========================

Name: st_ctrl

Overview:
- Parametrised front-panel mode controller for the light-pen screen.
- Takes three raw push-buttons (reset/stop, mode-advance, colour) and debounces each one.
- Runs a timed boot-blink sequence, then sequences NUM_MODES work modes with wrap-around, plus a COLOR overlay sub-mode that remembers the mode it was entered from.
- Adds long-press detection on the advance button and publishes the current state, sub-state and colour index to the display/draw datapath.

Parameters:
- NUM_MODES, 4: number of work modes (2..8); codes 3..3+NUM_MODES-1.
- NUM_COLORS, 8: colour palette entries cycled in COLOR (2..8).
- BLINK_STEPS, 4: boot-blink steps before entering work mode 0 (1..8).
- BLINK_CYC, 25000000: clock cycles per blink step (>=2).
- DEBOUNCE_CYC, 500000: consecutive stable cycles needed to accept a button level change (>=1).
- LONGPRESS_CYC, 100000000: cycles btn_change must stay debounced-high to raise a long-press event (> DEBOUNCE_CYC).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- btn_rst  in  1  raw button, active-high, asynchronous to clk.
- btn_change  in  1  raw button, active-high, asynchronous.
- btn_color  in  1  raw button, active-high, asynchronous.
- state  out  4  current state code: 0 RST, 1 STOP, 2 COLOR, 3+k work mode k.
- state_deep  out  3  blink step while in RST, colour index while in COLOR, 0 otherwise.
- color_idx  out  3  persistent selected colour index.
- blink  out  1  equals state_deep[0] while in RST, else 0.
- state_changed  out  1  one-cycle pulse, high the cycle after state changes value.

Behaviour:
- Reset (rst_n low, asynchronous): state=RST, state_deep=0, color_idx=0, blink=0, state_changed=0, saved mode=0, all counters and synchronisers cleared, debounced levels=0.
- Input path per button:
  - 2-FF synchroniser.
  - Debounced level toggles only after the synchroniser output differs from it for DEBOUNCE_CYC consecutive cycles; any agreeing cycle clears the count.
  - Press event: registered one-cycle pulse on the debounced rising edge.
- Long press: a hold counter runs while debounced btn_change=1. It raises ev_long for exactly one cycle when it reaches LONGPRESS_CYC, and does not repeat until release. A long press therefore yields a press event followed later by ev_long.
- Timing: the state register updates on the clock edge after the event pulse is high. Raw edge to state change = 2 + DEBOUNCE_CYC + 2 cycles.
- Event priority within one cycle: rst > color > long > change. Lower-priority events in the same cycle are dropped.
- RST state:
  - Counter increments every cycle.
  - At BLINK_CYC-1 the counter clears and state_deep increments.
  - When the step at state_deep=BLINK_STEPS-1 expires: go to work mode 0, state_deep=0.
  - ev_rst goes to STOP. Colour and change events are ignored.
- STOP state: ev_rst goes to RST with state_deep=0 and counter=0. All other events are ignored.
- Work mode k:
  - ev_change: k+1; wraps from NUM_MODES-1 to 0.
  - ev_color: save k, enter COLOR, state_deep=color_idx.
  - ev_long: go to mode 0.
  - ev_rst: go to STOP.
- COLOR state:
  - ev_change: color_idx = (color_idx+1) mod NUM_COLORS, and state_deep follows it.
  - ev_color: return to the saved mode.
  - ev_long: ignored.
  - ev_rst: go to STOP; the saved mode resets to 0.
- color_idx survives STOP/RST cycles; only rst_n clears it.
- state_changed: registered compare of state against its previous value. It does not pulse for state_deep-only changes.
- Asserting rst_n mid-debounce or mid-blink discards all progress. No event is generated on reset release even if a button is held; the button must be released and pressed again.

Test Plan (DEBOUNCE_CYC=4, BLINK_CYC=8, BLINK_STEPS=4, LONGPRESS_CYC=20, NUM_MODES=4, NUM_COLORS=3):
- Release rst_n, no buttons:
  - state=0 for 32 cycles.
  - state_deep steps 0,1,2,3 every 8 cycles; blink toggles.
  - state=3 at cycle 32, with state_changed pulsing one cycle later.
- In mode 3, 3-cycle glitch on btn_change: no change. Then a clean 10-cycle press: state=4 at 8 cycles after the raw edge. Three more presses give 5, 6, then wrap to 3.
- In mode 4, press btn_color: state=2, state_deep=0.
  - Press btn_change twice: color_idx 1, 2.
  - Press a third time: color_idx wraps to 0.
  - Press btn_color: state=4.
- In mode 5, hold btn_change 40 cycles: state=6 first, then state=3 when ev_long fires; no further events during the rest of the hold.
- In mode 4, press btn_rst: state=1.
  - Press btn_change: no change.
  - Press btn_rst: state=0, state_deep=0, blink restarts.
  - rst_n low mid-blink: state=0 immediately (asynchronously).
- btn_rst and btn_color debounced on the same cycle in mode 3: state=1, colour event dropped, color_idx unchanged.

Source files
------------

// File: rtl/st_ctrl.sv
// Front-panel mode controller: debounced buttons, boot-blink sequence,
// wrapping work modes and a COLOR overlay that returns to its entry mode.
module st_ctrl #(
    parameter int NUM_MODES     = 4,
    parameter int NUM_COLORS    = 8,
    parameter int BLINK_STEPS   = 4,
    parameter int BLINK_CYC     = 25000000,
    parameter int DEBOUNCE_CYC  = 500000,
    parameter int LONGPRESS_CYC = 100000000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_btn_rst,
    input  logic       i_btn_change,
    input  logic       i_btn_color,
    output logic [3:0] o_state,
    output logic [2:0] o_state_deep,
    output logic [2:0] o_color_idx,
    output logic       o_blink,
    output logic       o_state_changed
);

    localparam int DBW = $clog2(DEBOUNCE_CYC + 1);
    localparam int LPW = $clog2(LONGPRESS_CYC + 1);
    localparam int BCW = $clog2(BLINK_CYC);

    typedef enum logic [1:0] {
        S_RST   = 2'd0,
        S_STOP  = 2'd1,
        S_COLOR = 2'd2,
        S_WORK  = 2'd3
    } state_t;

    // Button index: 0 = rst/stop, 1 = change, 2 = colour.
    logic [2:0]     w_raw;
    logic [2:0]     w_target;
    logic [2:0]     r_sync1, r_sync2, r_armed, r_db, r_dbPrev, r_press;
    logic [1:0]     r_pipeValid;
    logic [DBW-1:0] r_dbCnt [3];
    logic [LPW-1:0] r_holdCnt;
    logic           r_evLong;

    assign w_raw = {i_btn_color, i_btn_change, i_btn_rst};

    // A button held through reset release stays unarmed until seen released,
    // so it cannot produce a press or long-press event.
    assign w_target = r_sync2 & r_armed;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1     <= '0;
            r_sync2     <= '0;
            r_pipeValid <= '0;
            r_armed     <= '0;
            r_db        <= '0;
            r_dbPrev    <= '0;
            r_press     <= '0;
            for (int i = 0; i < 3; i++) r_dbCnt[i] <= '0;
        end else begin
            r_sync1     <= w_raw;
            r_sync2     <= r_sync1;
            r_pipeValid <= {r_pipeValid[0], 1'b1};
            r_armed     <= r_armed | ({3{r_pipeValid[1]}} & ~r_sync2);
            r_dbPrev    <= r_db;
            r_press     <= r_db & ~r_dbPrev;
            for (int i = 0; i < 3; i++) begin
                if (w_target[i] != r_db[i]) begin
                    if (r_dbCnt[i] == DBW'(DEBOUNCE_CYC - 1)) begin
                        r_db[i]    <= w_target[i];
                        r_dbCnt[i] <= '0;
                    end else begin
                        r_dbCnt[i] <= r_dbCnt[i] + DBW'(1);
                    end
                end else begin
                    r_dbCnt[i] <= '0;
                end
            end
        end
    end

    // Hold counter saturates so the long-press pulse fires once per hold.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_holdCnt <= '0;
            r_evLong  <= 1'b0;
        end else if (r_db[1]) begin
            if (r_holdCnt != LPW'(LONGPRESS_CYC)) r_holdCnt <= r_holdCnt + LPW'(1);
            r_evLong <= (r_holdCnt == LPW'(LONGPRESS_CYC - 1));
        end else begin
            r_holdCnt <= '0;
            r_evLong  <= 1'b0;
        end
    end

    logic w_evRst, w_evColor, w_evLong, w_evChange;

    assign w_evRst    = r_press[0];
    assign w_evColor  = r_press[2] & ~r_press[0];
    assign w_evLong   = r_evLong & ~r_press[0] & ~r_press[2];
    assign w_evChange = r_press[1] & ~r_press[0] & ~r_press[2] & ~r_evLong;

    state_t         r_state, w_nextState;
    logic [2:0]     r_mode, w_nextMode;
    logic [2:0]     r_savedMode, w_nextSaved;
    logic [2:0]     r_deep, w_nextDeep;
    logic [2:0]     r_colorIdx, w_nextColor;
    logic [BCW-1:0] r_blinkCnt, w_nextBlinkCnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_RST;
            r_mode      <= '0;
            r_savedMode <= '0;
            r_deep      <= '0;
            r_colorIdx  <= '0;
            r_blinkCnt  <= '0;
        end else begin
            r_state     <= w_nextState;
            r_mode      <= w_nextMode;
            r_savedMode <= w_nextSaved;
            r_deep      <= w_nextDeep;
            r_colorIdx  <= w_nextColor;
            r_blinkCnt  <= w_nextBlinkCnt;
        end
    end

    always_comb begin
        w_nextState    = r_state;
        w_nextMode     = r_mode;
        w_nextSaved    = r_savedMode;
        w_nextDeep     = r_deep;
        w_nextColor    = r_colorIdx;
        w_nextBlinkCnt = r_blinkCnt;
        case (r_state)
            S_RST: begin
                if (w_evRst) begin
                    w_nextState    = S_STOP;
                    w_nextDeep     = '0;
                    w_nextBlinkCnt = '0;
                end else if (r_blinkCnt == BCW'(BLINK_CYC - 1)) begin
                    w_nextBlinkCnt = '0;
                    if (r_deep == 3'(BLINK_STEPS - 1)) begin
                        w_nextState = S_WORK;
                        w_nextMode  = '0;
                        w_nextDeep  = '0;
                    end else begin
                        w_nextDeep = r_deep + 3'd1;
                    end
                end else begin
                    w_nextBlinkCnt = r_blinkCnt + BCW'(1);
                end
            end
            S_STOP: begin
                if (w_evRst) begin
                    w_nextState    = S_RST;
                    w_nextDeep     = '0;
                    w_nextBlinkCnt = '0;
                end
            end
            S_WORK: begin
                if (w_evRst) begin
                    w_nextState = S_STOP;
                end else if (w_evColor) begin
                    w_nextSaved = r_mode;
                    w_nextState = S_COLOR;
                end else if (w_evLong) begin
                    w_nextMode = '0;
                end else if (w_evChange) begin
                    w_nextMode = (r_mode == 3'(NUM_MODES - 1)) ? 3'd0 : r_mode + 3'd1;
                end
            end
            S_COLOR: begin
                if (w_evRst) begin
                    w_nextState = S_STOP;
                    w_nextSaved = '0;
                end else if (w_evColor) begin
                    w_nextState = S_WORK;
                    w_nextMode  = r_savedMode;
                end else if (w_evChange) begin
                    w_nextColor = (r_colorIdx == 3'(NUM_COLORS - 1)) ? 3'd0 : r_colorIdx + 3'd1;
                end
            end
            default: w_nextState = S_RST;
        endcase
    end

    logic [3:0] w_stateOut;
    logic [3:0] r_prevState;
    logic       r_changed;

    assign w_stateOut = (r_state == S_WORK) ? 4'd3 + {1'b0, r_mode} : {2'b00, r_state};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prevState <= '0;
            r_changed   <= 1'b0;
        end else begin
            r_prevState <= w_stateOut;
            r_changed   <= (w_stateOut != r_prevState);
        end
    end

    assign o_state         = w_stateOut;
    assign o_state_deep    = (r_state == S_RST)   ? r_deep :
                             (r_state == S_COLOR) ? r_colorIdx : 3'd0;
    assign o_color_idx     = r_colorIdx;
    assign o_blink         = (r_state == S_RST) & r_deep[0];
    assign o_state_changed = r_changed;

endmodule

// File: tb/tb_st_ctrl.sv
// Directed bench for st_ctrl with small timing parameters; every expected
// value below is hand-computed from the controller's timing rules.
module tb_st_ctrl;

   localparam int DEB  = 4;
   localparam int BCYC = 8;
   localparam int BST  = 4;
   localparam int LONG = 20;

   logic       clk = 1'b0;
   logic       rstN;
   logic       btnRst, btnChange, btnColor;
   logic [3:0] state;
   logic [2:0] stateDeep, colorIdx;
   logic       blink, stateChanged;

   int vectorCount = 0;
   int missCount   = 0;

   st_ctrl #(
      .NUM_MODES    (4),
      .NUM_COLORS   (3),
      .BLINK_STEPS  (BST),
      .BLINK_CYC    (BCYC),
      .DEBOUNCE_CYC (DEB),
      .LONGPRESS_CYC(LONG)
   ) dut (
      .i_clk          (clk),
      .i_rst_n        (rstN),
      .i_btn_rst      (btnRst),
      .i_btn_change   (btnChange),
      .i_btn_color    (btnColor),
      .o_state        (state),
      .o_state_deep   (stateDeep),
      .o_color_idx    (colorIdx),
      .o_blink        (blink),
      .o_state_changed(stateChanged)
   );

   // Free-running 10 ns clock
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Advance n rising edges and settle 1 ns past the last one
   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic setButton(input int idx, input logic val);
      case (idx)
         0: btnRst = val;
         1: btnChange = val;
         default: btnColor = val;
      endcase
   endtask

   // Clean press: high for hold edges, then low long enough to debounce release
   task automatic applyStimulus(input int idx, input int hold, input int gap);
      setButton(idx, 1'b1);
      waitCycles(hold);
      setButton(idx, 1'b0);
      waitCycles(gap);
   endtask

   // Main directed sequence
   initial begin
      rstN = 1'b0;
      btnRst = 1'b0;
      btnChange = 1'b0;
      btnColor = 1'b0;
      waitCycles(2);
      checkOutput("rstState", state, 0);
      checkOutput("rstDeep", stateDeep, 0);
      checkOutput("rstColor", colorIdx, 0);
      checkOutput("rstBlink", blink, 0);
      checkOutput("rstChanged", stateChanged, 0);

      rstN = 1'b1;
      waitCycles(7);
      checkOutput("blinkDeep7", stateDeep, 0);
      checkOutput("blinkBlink7", blink, 0);
      waitCycles(1);
      checkOutput("blinkDeep8", stateDeep, 1);
      checkOutput("blinkBlink8", blink, 1);
      waitCycles(8);
      checkOutput("blinkDeep16", stateDeep, 2);
      checkOutput("blinkBlink16", blink, 0);
      waitCycles(8);
      checkOutput("blinkDeep24", stateDeep, 3);
      checkOutput("blinkBlink24", blink, 1);
      waitCycles(7);
      checkOutput("bootState31", state, 0);
      waitCycles(1);
      checkOutput("bootState32", state, 3);
      checkOutput("bootDeep32", stateDeep, 0);
      checkOutput("bootBlink32", blink, 0);
      checkOutput("bootChanged32", stateChanged, 0);
      waitCycles(1);
      checkOutput("bootChanged33", stateChanged, 1);
      waitCycles(1);
      checkOutput("bootChanged34", stateChanged, 0);

      setButton(1, 1'b1);
      waitCycles(3);
      setButton(1, 1'b0);
      waitCycles(12);
      checkOutput("glitchState", state, 3);

      setButton(1, 1'b1);
      waitCycles(7);
      checkOutput("pressLat7", state, 3);
      waitCycles(1);
      checkOutput("pressLat8", state, 4);
      waitCycles(1);
      checkOutput("pressChanged", stateChanged, 1);
      waitCycles(1);
      setButton(1, 1'b0);
      waitCycles(10);
      applyStimulus(1, 10, 10);
      checkOutput("mode5", state, 5);
      applyStimulus(1, 10, 10);
      checkOutput("mode6", state, 6);
      applyStimulus(1, 10, 10);
      checkOutput("modeWrap", state, 3);

      applyStimulus(1, 10, 10);
      checkOutput("toMode4", state, 4);
      applyStimulus(2, 10, 10);
      checkOutput("colorEnter", state, 2);
      checkOutput("colorDeep0", stateDeep, 0);
      applyStimulus(1, 10, 10);
      checkOutput("colorIdx1", colorIdx, 1);
      checkOutput("colorDeep1", stateDeep, 1);
      applyStimulus(1, 10, 10);
      checkOutput("colorIdx2", colorIdx, 2);
      applyStimulus(1, 10, 10);
      checkOutput("colorWrap", colorIdx, 0);
      checkOutput("colorWrapDeep", stateDeep, 0);
      applyStimulus(2, 10, 10);
      checkOutput("colorReturn", state, 4);
      checkOutput("colorReturnDeep", stateDeep, 0);

      applyStimulus(1, 10, 10);
      checkOutput("toMode5", state, 5);
      setButton(1, 1'b1);
      waitCycles(8);
      checkOutput("longFirst", state, 6);
      waitCycles(18);
      checkOutput("longBefore", state, 6);
      waitCycles(1);
      checkOutput("longFire", state, 3);
      waitCycles(13);
      setButton(1, 1'b0);
      waitCycles(20);
      checkOutput("longAfter", state, 3);

      applyStimulus(1, 10, 10);
      checkOutput("toMode4b", state, 4);
      setButton(0, 1'b1);
      waitCycles(7);
      checkOutput("stopLat7", state, 4);
      waitCycles(1);
      checkOutput("stopLat8", state, 1);
      waitCycles(2);
      setButton(0, 1'b0);
      waitCycles(10);
      applyStimulus(1, 10, 10);
      checkOutput("stopIgnore", state, 1);
      setButton(0, 1'b1);
      waitCycles(8);
      checkOutput("restartState", state, 0);
      checkOutput("restartDeep", stateDeep, 0);
      checkOutput("restartBlink", blink, 0);
      waitCycles(2);
      setButton(0, 1'b0);
      waitCycles(10);
      checkOutput("restartDeep12", stateDeep, 1);
      checkOutput("restartBlink12", blink, 1);
      rstN = 1'b0;
      #1;
      checkOutput("asyncState", state, 0);
      checkOutput("asyncDeep", stateDeep, 0);
      checkOutput("asyncBlink", blink, 0);
      waitCycles(2);
      rstN = 1'b1;
      waitCycles(32);
      checkOutput("reboot", state, 3);

      btnRst = 1'b1;
      btnColor = 1'b1;
      waitCycles(8);
      checkOutput("prioState", state, 1);
      checkOutput("prioColor", colorIdx, 0);
      waitCycles(2);
      btnRst = 1'b0;
      btnColor = 1'b0;
      waitCycles(10);
      checkOutput("prioHold", state, 1);

      applyStimulus(0, 10, 10);
      waitCycles(20);
      checkOutput("reboot2", state, 3);
      applyStimulus(2, 10, 10);
      applyStimulus(1, 10, 10);
      checkOutput("persistSet", colorIdx, 1);
      applyStimulus(2, 10, 10);
      checkOutput("persistBack", state, 3);
      applyStimulus(0, 10, 10);
      checkOutput("persistStop", state, 1);
      applyStimulus(0, 10, 10);
      checkOutput("persistRst", state, 0);
      checkOutput("persistColor", colorIdx, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
